// File: rtl/alu_mdu.sv
// ---------------------------------------------------------------------------
// alu_mdu -- single-issue ALU with an iterative multiply/divide unit.
//
// Base ALU ops (i_op[4]=0) complete in one cycle. M-extension ops
// (i_op[4]=1) run one bit per cycle for WIDTH cycles: shift-add multiply,
// or restoring divide on operand magnitudes with a sign fix-up at the end.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid / o_ready     request handshake (accepted only in IDLE)
//   i_op                  operation code
//   i_operand_a/b         operands, sampled at acceptance only
//   i_kill                abort an operation in BUSY or DONE
//   o_valid / i_ready     result handshake (o_valid only in DONE)
//   o_result              result, held stable while o_valid
//   o_busy                iterative operation in progress
// ---------------------------------------------------------------------------
module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [4:0]       i_op,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   input  logic             i_kill,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q;
   logic [2:0]         op_q;     // latched M-op selector
   logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q;    // mul: {partial, multiplier}; div: {rem, quotient}
   logic               neg_q_q;  // negate product / quotient at the end
   logic               neg_r_q;  // negate remainder at the end
   logic               bzero_q;  // divide by zero

   logic accept, last_iter;

   assign accept    = i_valid && (state_q == IDLE);
   assign last_iter = (cnt_q == SHW'(WIDTH - 1));

   // ------------------------------------------------------------------ FSM
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the clock edge, independent of order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first; otherwise an
   // unassigned path would hold its old value and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept)                state_d = i_op[4] ? BUSY : DONE;
         BUSY: if (i_kill)                state_d = IDLE;
               else if (last_iter)        state_d = DONE;
         DONE: if (i_kill || i_ready)     state_d = IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   assign o_ready = (state_q == IDLE);
   assign o_busy  = (state_q == BUSY);
   assign o_valid = (state_q == DONE);

   // ------------------------------------------------------------- base ALU
   logic [WIDTH-1:0] alu_res;
   logic [SHW-1:0]   shamt;

   always_comb begin
      alu_res = '0;
      shamt   = i_operand_b[SHW-1:0];
      case (i_op[3:2])
         2'b00: case (i_op[1:0])
            2'b00: alu_res = i_operand_a + i_operand_b;
            2'b01: alu_res = i_operand_a - i_operand_b;
            2'b10: alu_res = {{(WIDTH-1){1'b0}}, $signed(i_operand_a) < $signed(i_operand_b)};
            2'b11: alu_res = {{(WIDTH-1){1'b0}}, i_operand_a < i_operand_b};
            default: alu_res = '0;
         endcase
         2'b01: case (i_op[1:0])
            2'b00: alu_res = i_operand_a << shamt;
            2'b01: alu_res = i_operand_a >> shamt;
            2'b11: alu_res = WIDTH'($signed(i_operand_a) >>> shamt);
            default: alu_res = '0;
         endcase
         2'b10: case (i_op[1:0])
            2'b00: alu_res = i_operand_a & i_operand_b;
            2'b01: alu_res = i_operand_a | i_operand_b;
            2'b10: alu_res = i_operand_a ^ i_operand_b;
            default: alu_res = i_operand_b;
         endcase
         default: alu_res = '0;
      endcase
   end

   // ------------------------------------------------ M-op operand prepare
   // Which operands are treated as signed: MUL/MULH/MULHSU take a signed A,
   // MUL/MULH take a signed B; DIV/REM take both signed.
   logic             signed_a, signed_b, neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b;

   always_comb begin
      signed_a = i_op[2] ? ~i_op[0] : (i_op[1:0] != 2'b11);
      signed_b = i_op[2] ? ~i_op[0] : ~i_op[1];
      neg_a    = signed_a & i_operand_a[WIDTH-1];
      neg_b    = signed_b & i_operand_b[WIDTH-1];
      mag_a    = neg_a ? -i_operand_a : i_operand_a;
      mag_b    = neg_b ? -i_operand_b : i_operand_b;
   end

   // ---------------------------------------------------- one iteration step
   logic [WIDTH:0]     mul_sum, div_shift, div_trial;
   logic               div_ok;
   logic [WIDTH-1:0]   rem_nxt, quo_fix, rem_fix, mdu_res;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt, prod_s;

   always_comb begin
      // Shift-add: add the multiplicand to the upper half when the current
      // multiplier bit is set, then shift the whole register right.
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_nxt   = {mul_sum, acc_q[WIDTH-1:1]};
      // Restoring divide: shift the next dividend bit into the remainder and
      // keep the difference only when it did not go negative.
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd_q};
      div_ok    = ~div_trial[WIDTH];
      rem_nxt   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_nxt   = {rem_nxt, acc_q[WIDTH-2:0], div_ok};
      acc_nxt   = op_q[2] ? div_nxt : mul_nxt;

      // Final sign fix-up on the last step's values. A zero divisor already
      // leaves the dividend in the remainder; only the quotient is forced.
      prod_s  = neg_q_q ? -mul_nxt : mul_nxt;
      quo_fix = bzero_q ? '1 : (neg_q_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0]);
      rem_fix = neg_r_q ? -rem_nxt : rem_nxt;
      if (op_q[2])                 mdu_res = op_q[1] ? rem_fix : quo_fix;
      else if (op_q[1:0] == 2'b00) mdu_res = prod_s[WIDTH-1:0];
      else                         mdu_res = prod_s[2*WIDTH-1:WIDTH];
   end

   // ------------------------------------------------------------- datapath
   // NOTE: datapath registers are reset too, so the counter and o_result are
   // known zero while reset is held and nothing leaks from an aborted op.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q    <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         bzero_q  <= 1'b0;
         o_result <= '0;
      end else if (accept) begin
         if (i_op[4]) begin
            op_q    <= i_op[2:0];
            opnd_q  <= i_op[2] ? mag_b : mag_a;
            acc_q   <= {{WIDTH{1'b0}}, (i_op[2] ? mag_a : mag_b)};
            neg_q_q <= neg_a ^ neg_b;
            neg_r_q <= neg_a;
            bzero_q <= (i_operand_b == '0);
            cnt_q   <= '0;
         end else begin
            o_result <= alu_res;
         end
      end else if (state_q == BUSY) begin
         if (i_kill) begin
            cnt_q <= '0;
         end else begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + SHW'(1);
            if (last_iter) o_result <= mdu_res;
         end
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu -- self-checking bench for alu_mdu at WIDTH=32 and WIDTH=8.
//
// Each width gets its own DUT, driver and monitor running in parallel on a
// shared clock. The monitor predicts every accepted request with a plain
// arithmetic model and checks latency, busy time, result and hold behaviour
// on every cycle. Directed requests additionally check hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_mdu;

   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_SLT   = 5'b00010;
   localparam logic [4:0] OP_SLTU  = 5'b00011;
   localparam logic [4:0] OP_SRA   = 5'b00111;
   localparam logic [4:0] OP_MUL   = 5'b10000;
   localparam logic [4:0] OP_MULH  = 5'b10001;
   localparam logic [4:0] OP_MULHU = 5'b10011;
   localparam logic [4:0] OP_DIV   = 5'b10100;
   localparam logic [4:0] OP_DIVU  = 5'b10101;
   localparam logic [4:0] OP_REM   = 5'b10110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference behaviour at width w, computed with 64-bit integer arithmetic.
   function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input int w);
      longint unsigned mask, ua, ub;
      longint          sa, sb, p, smin;
      int              amt;
      mask = (longint'(1) << w) - 1;
      ua   = a & mask;
      ub   = b & mask;
      sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
      sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
      smin = -(longint'(1) << (w - 1));
      amt  = int'(ub & longint'(w - 1));
      if (!op[4]) begin
         case (op[3:0])
            4'b0000: return (ua + ub) & mask;
            4'b0001: return (ua - ub) & mask;
            4'b0010: return (sa < sb) ? 64'd1 : 64'd0;
            4'b0011: return (ua < ub) ? 64'd1 : 64'd0;
            4'b0100: return (ua << amt) & mask;
            4'b0101: return ua >> amt;
            4'b0111: begin p = sa >>> amt; return p & mask; end
            4'b1000: return ua & ub;
            4'b1001: return ua | ub;
            4'b1010: return ua ^ ub;
            4'b1011: return ub;
            default: return 64'd0;
         endcase
      end
      case (op[2:0])
         3'b000: begin p = sa * sb; return p & mask; end
         3'b001: begin p = sa * sb; p = p >>> w; return p & mask; end
         3'b010: begin p = sa * longint'(ub); p = p >>> w; return p & mask; end
         3'b011: return ((ua * ub) >> w) & mask;
         3'b100: begin
            if (ub == 0) return mask;
            if (sa == smin && sb == -1) return ua;
            p = sa / sb; return p & mask;
         end
         3'b101: return (ub == 0) ? mask : ua / ub;
         3'b110: begin
            if (ub == 0) return ua;
            if (sa == smin && sb == -1) return 64'd0;
            p = sa % sb; return p & mask;
         end
         default: return (ub == 0) ? ua : ua % ub;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int W = (g == 0) ? 32 : 8;
      localparam logic [W-1:0] ONES = '1;
      localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};

      logic         rst_n, valid, ready_o, kill, valid_o, ready_i, busy;
      logic [4:0]   op;
      logic [W-1:0] a, b, res;
      bit           fin = 1'b0;

      alu_mdu #(.WIDTH(W)) dut (
         .i_clk       (clk),
         .i_rst_n     (rst_n),
         .i_valid     (valid),
         .o_ready     (ready_o),
         .i_op        (op),
         .i_operand_a (a),
         .i_operand_b (b),
         .i_kill      (kill),
         .o_valid     (valid_o),
         .i_ready     (ready_i),
         .o_result    (res),
         .o_busy      (busy)
      );

      // ------------------------------------------------------------ monitor
      bit           pending, seen;
      int           cnt, exp_lat, busy_cnt, exp_busy, accepts;
      logic [W-1:0] exp_res, held;

      initial begin
         pending = 0; seen = 0; accepts = 0;
         cnt = 0; exp_lat = 0; busy_cnt = 0; exp_busy = 0;
         exp_res = '0; held = '0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               pending = 0;
            end else begin
               if (pending) begin
                  cnt++;
                  check("ready low while in flight", 64'(ready_o), 64'd0);
                  if (!seen) begin
                     if (busy) busy_cnt++;
                     if (valid_o || cnt >= exp_lat) begin
                        check("latency", 64'(cnt), 64'(exp_lat));
                        check("valid at latency", 64'(valid_o), 64'd1);
                        check("busy cycles", 64'(busy_cnt), 64'(exp_busy));
                        if (valid_o) begin
                           check("result vs model", 64'(res), 64'(exp_res));
                           held = res;
                           seen = 1;
                        end else begin
                           pending = 0;
                        end
                     end
                  end else begin
                     check("result hold", 64'({valid_o, res}), 64'({1'b1, held}));
                  end
                  if (pending && kill && (busy || valid_o)) pending = 0;
                  else if (pending && valid_o && ready_i)  pending = 0;
               end else begin
                  check("idle outputs", 64'({valid_o, busy, ready_o}), 64'd1);
               end
               if (valid && ready_o) begin
                  pending  = 1;
                  seen     = 0;
                  cnt      = 0;
                  busy_cnt = 0;
                  accepts++;
                  exp_res  = W'(model(op, 64'(a), 64'(b), W));
                  exp_lat  = op[4] ? W + 1 : 1;
                  exp_busy = op[4] ? W : 0;
               end
            end
         end
      end

      // ------------------------------------------------------------- driver
      function automatic logic [W-1:0] pick();
         case ($urandom_range(0, 5))
            0:       return '0;
            1:       return ONES;
            2:       return MIN;
            3:       return W'($urandom_range(0, 9));
            default: return W'($urandom);
         endcase
      endfunction

      // Called just after a rising edge; returns just after the accepting edge.
      task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input bit k, output int waits);
         waits = 0;
         op = o; a = x; b = y; kill = k; valid = 1'b1;
         @(negedge clk);
         while (!ready_o && waits < 50) begin
            waits++;
            @(negedge clk);
         end
         check("request accepted", 64'(ready_o), 64'd1);
         @(posedge clk);
         #1;
         valid = 1'b0; kill = 1'b0;
         op = 5'($urandom); a = W'($urandom); b = W'($urandom);
      endtask

      task automatic wait_valid(output bit ok);
         ok = 0;
         for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (valid_o) begin ok = 1; break; end
         end
         if (!ok) check("result timeout", 64'd0, 64'd1);
      endtask

      task automatic consume(input int d);
         repeat (d + 1) @(posedge clk);
         #1 ready_i = 1'b1;
         @(posedge clk);
         #1 ready_i = 1'b0;
      endtask

      task automatic run_dir(input string name, input logic [4:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] lit, input bit k);
         int w;
         bit ok;
         issue(o, x, y, k, w);
         wait_valid(ok);
         if (ok) check(name, 64'(res), 64'(lit));
         consume(0);
      endtask

      initial begin
         int  w, n0, mode;
         bit  ok;
         logic [W-1:0] h;
         rst_n = 1'b0; valid = 1'b0; kill = 1'b0; ready_i = 1'b0;
         op = '0; a = '0; b = '0;
         #12;
         check("reset outputs", 64'({valid_o, busy, ready_o, res}), 64'({3'b001, {W{1'b0}}}));
         @(posedge clk);
         #1 rst_n = 1'b1;

         run_dir("ADD wrap",        OP_ADD,   ONES, W'(1), W'(0), 1'b0);
         run_dir("SRA masked shamt", OP_SRA,  MIN, W'(W + 1), {2'b11, {(W-2){1'b0}}}, 1'b0);
         run_dir("SLT -1<1",        OP_SLT,   ONES, W'(1), W'(1), 1'b0);
         run_dir("SLTU -1<1",       OP_SLTU,  ONES, W'(1), W'(0), 1'b0);
         run_dir("MULH min*min",    OP_MULH,  MIN, MIN, {2'b01, {(W-2){1'b0}}}, 1'b0);
         run_dir("MULHU ones*ones", OP_MULHU, ONES, ONES, ONES - W'(1), 1'b0);
         run_dir("MUL 7*-3",        OP_MUL,   W'(7), W'(-3), W'(-21), 1'b0);
         run_dir("DIV -7/2",        OP_DIV,   W'(-7), W'(2), W'(-3), 1'b0);
         run_dir("REM -7/2",        OP_REM,   W'(-7), W'(2), ONES, 1'b0);
         run_dir("DIVU 5/0",        OP_DIVU,  W'(5), W'(0), ONES, 1'b0);
         run_dir("REM 5/0",         OP_REM,   W'(5), W'(0), W'(5), 1'b0);
         run_dir("DIV min/-1",      OP_DIV,   MIN, ONES, MIN, 1'b0);
         run_dir("REM min/-1",      OP_REM,   MIN, ONES, W'(0), 1'b0);

         // Back-to-back base ops with i_valid and i_ready held high.
         n0 = accepts;
         op = OP_ADD; a = W'(2); b = W'(3); valid = 1'b1; ready_i = 1'b1;
         repeat (6) @(posedge clk);
         #1 valid = 1'b0; ready_i = 1'b0;
         check("back-to-back accepts in 6 cycles", 64'(accepts - n0), 64'd3);

         // Backpressure: result held for 10 cycles, then a new request goes in
         // on the cycle after DONE is left.
         issue(OP_ADD, W'(10), W'(20), 1'b0, w);
         wait_valid(ok);
         check("backpressure result", 64'(res), 64'(30));
         h = res;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("backpressure hold", 64'({valid_o, ready_o, res}), 64'({2'b10, h}));
         end
         @(posedge clk);
         #1 ready_i = 1'b1;
         @(posedge clk);
         #1 ready_i = 1'b0;
         issue(OP_ADD, W'(1), W'(1), 1'b0, w);
         check("accept right after DONE", 64'(w), 64'd0);
         wait_valid(ok);
         consume(0);

         // Kill a divide mid-flight, then an ADD issued with i_kill still high.
         issue(OP_DIVU, W'($urandom), W'(3), 1'b0, w);
         repeat (5) @(posedge clk);
         #1 kill = 1'b1;
         @(posedge clk);
         #1 kill = 1'b0;
         run_dir("ADD after kill", OP_ADD, W'(2), W'(3), W'(5), 1'b1);

         // Asynchronous reset in the middle of a multiply.
         issue(OP_MUL, W'($urandom), W'($urandom), 1'b0, w);
         repeat (10) @(posedge clk);
         #3 rst_n = 1'b0;
         #1 check("async reset mid-MUL", 64'({valid_o, busy, ready_o, res}),
                  64'({3'b001, {W{1'b0}}}));
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
         run_dir("MUL 3*4 after reset", OP_MUL, W'(3), W'(4), W'(12), 1'b0);

         // Randomized traffic with kills, early i_ready and random delays.
         for (int n = 0; n < 150; n++) begin
            mode = $urandom_range(0, 7);
            issue(5'($urandom), pick(), pick(), ($urandom_range(0, 7) == 0), w);
            if (mode == 0) begin
               repeat ($urandom_range(0, W + 3)) @(posedge clk);
               #1 kill = 1'b1;
               @(posedge clk);
               #1 kill = 1'b0;
            end else if (mode == 1) begin
               ready_i = 1'b1;
               wait_valid(ok);
               @(posedge clk);
               #1 ready_i = 1'b0;
            end else begin
               wait_valid(ok);
               consume($urandom_range(0, 3));
            end
         end
         repeat (3) @(posedge clk);
         fin = 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      wait (inst[0].fin && inst[1].fin);
      #20;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
